// File: rtl/hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
// Field bit indices follow the decoder's one-hot encodings.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam int MULT_S_BIT = 0;
    localparam int MULT_U_BIT = 1;
    localparam int DIV_S_BIT  = 0;
    localparam int DIV_U_BIT  = 1;
    localparam int MFHL_LO_BIT = 0;
    localparam int MFHL_HI_BIT = 1;
    localparam int MTHL_LO_BIT = 0;
    localparam int MTHL_HI_BIT = 1;

    // |0x80000000| stays 0x80000000 and is treated as unsigned downstream.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Iterative restoring divider: one quotient bit per cycle over DIV_ITER cycles.
// Outputs are sign-corrected and valid in the cycle after done.
module div_core
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITER - 1);

    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvs_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    logic [32:0] part_rem;
    logic [31:0] sub_lo;
    logic        fits;

    // Partial remainder needs 33 bits; the difference always fits in 32 when taken.
    assign part_rem = {rem_q, quo_q[31]};
    assign fits     = part_rem >= {1'b0, dvs_q};
    assign sub_lo   = part_rem[31:0] - dvs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= abs_val(a, is_signed);
            dvs_q   <= abs_val(b, is_signed);
            neg_q_q <= is_signed & (a[31] ^ b[31]);
            neg_r_q <= is_signed & a[31];
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? sub_lo : part_rem[31:0];
            quo_q <= {quo_q[30:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST)
                run_q <= 1'b0;
        end
    end

    assign done      = run_q & (cnt_q == LAST);
    assign quotient  = neg_q_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = neg_r_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register unit: single-cycle multiply, mthi/mtlo, mfhi/mflo and a
// 33-cycle iterative divide that stalls the EX stage while busy.
//
// state    | meaning
// IDLE     | accepting ops; mult/mthl complete at the accept edge
// DIV_RUN  | divider iterating, one quotient bit per cycle
// DIV_DONE | divider result ready; HI/LO written at the closing edge
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        flush,
    input  logic [1:0]  MULT,
    input  logic [1:0]  DIV,
    input  logic [1:0]  MFHL,
    input  logic [1:0]  MTHL,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        busy
);

    state_t      state;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        op;
    logic        accept;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign op        = valid & ~flush & (|{MULT, DIV, MFHL, MTHL});
    assign busy      = (state != IDLE);
    assign accept    = op & ~busy;
    assign stall     = busy & op;
    assign div_start = accept & (|DIV);

    // Extending to 64 bits first makes the low 64 product bits exact for both signednesses.
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (DIV[DIV_S_BIT]),
        .a         (src_a),
        .b         (src_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (|DIV)
                            state <= DIV_RUN;
                        else if (|MULT)
                            {hi, lo} <= MULT[MULT_S_BIT] ? prod_s : prod_u;
                        else if (MTHL[MTHL_LO_BIT])
                            lo <= src_a;
                        else if (MTHL[MTHL_HI_BIT])
                            hi <= src_a;
                    end
                end
                DIV_RUN: begin
                    if (div_done)
                        state <= DIV_DONE;
                end
                DIV_DONE: begin
                    lo    <= div_quo;
                    hi    <= div_rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (MFHL[MFHL_LO_BIT])
            rdata = lo;
        else if (MFHL[MFHL_HI_BIT])
            rdata = hi;
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv with hand-computed expectations.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        flush;
    logic [1:0]  MULT;
    logic [1:0]  DIV;
    logic [1:0]  MFHL;
    logic [1:0]  MTHL;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] rdata;
    logic        stall;
    logic        busy;

    int total;
    int bad;

    hilo_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .flush (flush),
        .MULT  (MULT),
        .DIV   (DIV),
        .MFHL  (MFHL),
        .MTHL  (MTHL),
        .src_a (src_a),
        .src_b (src_b),
        .rdata (rdata),
        .stall (stall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        valid = 1'b0;
        flush = 1'b0;
        MULT  = 2'b00;
        DIV   = 2'b00;
        MFHL  = 2'b00;
        MTHL  = 2'b00;
        src_a = '0;
        src_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rdata is combinational, so HI/LO can be read between edges.
    task automatic chk_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [1:0] saved;
        saved = MFHL;
        MFHL = 2'b10;
        #1;
        chk({tag, "_hi"}, rdata, exp_hi);
        MFHL = 2'b01;
        #1;
        chk({tag, "_lo"}, rdata, exp_lo);
        MFHL = saved;
        #1;
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, output int cyc);
        valid = 1'b1;
        DIV   = sgn ? 2'b01 : 2'b10;
        src_a = a;
        src_b = b;
        tick();
        clear_in();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_in();

        #12;
        valid = 1'b1;
        MULT  = 2'b01;
        MFHL  = 2'b10;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        clear_in();
        rst = 1'b0;
        tick();

        valid = 1'b1; MULT = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'h0000_0002;
        tick();
        clear_in();
        chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        valid = 1'b1; MULT = 2'b10; src_a = 32'hFFFF_FFFF; src_b = 32'h0000_0002;
        tick();
        clear_in();
        chk_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        valid = 1'b1; MULT = 2'b10; MTHL = 2'b01; src_a = 32'd3; src_b = 32'd5;
        tick();
        clear_in();
        chk_hl("prio_mult", 32'h0, 32'h0000_000F);

        valid = 1'b1; MTHL = 2'b10; src_a = 32'h1234_5678;
        tick();
        clear_in();
        chk_hl("mthi", 32'h1234_5678, 32'h0000_000F);

        valid = 1'b1; MTHL = 2'b11; src_a = 32'hCAFE_BABE;
        tick();
        clear_in();
        chk_hl("mtlo_prio", 32'h1234_5678, 32'hCAFE_BABE);

        valid = 1'b1; flush = 1'b1; DIV = 2'b01; src_a = 32'd100; src_b = 32'd7;
        tick();
        clear_in();
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk_hl("flush", 32'h1234_5678, 32'hCAFE_BABE);

        do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, cyc);
        chk("div_busy_cycles", cyc, 32'd33);
        chk_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_div(32'h0000_0064, 32'h0, 1'b0, cyc);
        chk("divu0_cycles", cyc, 32'd33);
        chk_hl("divu0", 32'h0000_0064, 32'hFFFF_FFFF);

        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, cyc);
        chk_hl("divu_wide", 32'h0000_0001, 32'h0000_0001);

        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc);
        chk_hl("div_minint", 32'h0000_0000, 32'h8000_0000);

        // mfhi right after a div accept: stalls, sees old HI until the result lands.
        valid = 1'b1; DIV = 2'b01; src_a = 32'd100; src_b = 32'd7;
        tick();
        clear_in();
        valid = 1'b1; MFHL = 2'b10;
        #1;
        chk("mfhi_stall", {31'd0, stall}, 32'd1);
        chk("mfhi_old_hi", rdata, 32'h0);
        cyc = 0;
        while (stall === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("mfhi_stall_cycles", cyc, 32'd33);
        chk("mfhi_new_hi", rdata, 32'd2);
        clear_in();
        chk_hl("div_100_7", 32'd2, 32'd14);

        // op arriving during DIV_DONE waits one cycle, then sees the new HI/LO.
        valid = 1'b1; DIV = 2'b01; src_a = 32'd20; src_b = 32'd3;
        tick();
        clear_in();
        repeat (32) @(posedge clk);
        #1;
        chk("done_busy", {31'd0, busy}, 32'd1);
        valid = 1'b1; MTHL = 2'b10; src_a = 32'h0000_AAAA;
        #1;
        chk("done_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk_hl("done_result", 32'd2, 32'd6);
        tick();
        clear_in();
        chk_hl("mthi_after_div", 32'h0000_AAAA, 32'd6);

        // Asynchronous reset in the middle of a divide.
        valid = 1'b1; DIV = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        tick();
        clear_in();
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk_hl("mid_rst", 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk_hl("post_rst", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Ports SHALL be (clock and reset first): clk in 1, single clock, all state on rising edge; rst in 1, asynchronous active-high reset.
REQ-002 valid in 1: EX-stage instruction valid; flush in 1: EX-stage instruction cancelled this cycle.
REQ-003 MULT in 2 ([1]=multu, [0]=mult); DIV in 2 ([1]=divu, [0]=div); MFHL in 2 ([1]=mfhi, [0]=mflo); MTHL in 2 ([1]=mthi, [0]=mtlo); encodings as produced by the decoder.
REQ-004 src_a in 32: rs operand (dividend, multiplicand, mthi/mtlo data); src_b in 32: rt operand (divisor, multiplier).
REQ-005 rdata out 32: mfhi/mflo result; stall out 1: hold the EX stage; busy out 1: divide in progress.

Function
REQ-006 "op" SHALL mean valid & ~flush & (MULT|DIV|MFHL|MTHL != 0); "accept" SHALL mean op & ~busy.
REQ-007 State machine SHALL have IDLE, DIV_RUN and DIV_DONE; busy = (state != IDLE).
REQ-008 stall SHALL equal busy & op, combinational; ops are never dropped, only delayed.
REQ-009 Priority on multiple decoded ops SHALL be DIV > MULT > MTHL; within a field, bit[0] (signed or lo) wins.
REQ-010 mult/multu accept SHALL write {HI,LO} = 64-bit product (signed or unsigned) at the accept edge; latency 1.
REQ-011 mthi/mtlo accept SHALL write src_a to HI/LO at the accept edge; the other register is unchanged.
REQ-012 rdata SHALL be combinational: HI when MFHL[1], LO when MFHL[0], else 0; it is valid only when stall=0.
REQ-013 div/divu accept SHALL latch |src_a|, |src_b| and signs (magnitudes are unsigned for divu) and move IDLE->DIV_RUN.
REQ-014 DIV_RUN SHALL run a restoring divider at 1 quotient bit per cycle for exactly 32 cycles (5-bit counter 0..31), then move to DIV_DONE.
REQ-015 DIV_DONE SHALL apply signs (quotient negated if signs differ, remainder takes dividend sign; div only), write LO=quotient and HI=remainder at its closing edge, and return to IDLE.
REQ-016 busy SHALL be high for exactly 33 cycles per divide; HI/LO hold their old values until the DIV_DONE edge.
REQ-017 Divide by zero SHALL produce raw quotient 0xFFFFFFFF and raw remainder |dividend|, followed by normal sign correction; no trap.
REQ-018 flush SHALL only suppress accept in its own cycle; flush during DIV_RUN/DIV_DONE SHALL NOT abort the divide.
REQ-019 An op arriving in DIV_DONE SHALL stall that cycle and be accepted in the following IDLE cycle against the updated HI/LO.
REQ-020 Unsigned width rules: divider partial remainder 33 bits; |0x80000000| = 0x80000000 unsigned, with no overflow flag.

Reset
REQ-021 rst SHALL asynchronously force state=IDLE, HI=LO=0, counter=0 and divider datapath registers=0.
REQ-022 Under rst, busy=0, stall=0 and rdata=0; reset mid-divide SHALL discard the result.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE/DIV_RUN/DIV_DONE), field bit-index constants for MULT/DIV/MFHL/MTHL, and DIV_ITER=32.
REQ-024 The iterative divider SHALL be a sub-module div_core (start, signed, a, b -> done, quotient, remainder); the multiplier stays inline.

Verification
REQ-025 mult with 0xFFFFFFFF, 0x00000002 -> next edge HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-026 div with 0xFFFFFFF9 (-7), 0x00000002 -> busy high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-027 divu with 0x00000064, 0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-028 mfhi one cycle after a div accept -> stall high until busy falls, then rdata equals the new HI.
REQ-029 rst asserted at divide iteration 10 -> busy=0 and HI=LO=0 immediately, without waiting for a clock edge.
REQ-030 div with flush=1 in the same cycle -> busy stays 0 and HI/LO are unchanged.
